// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI byte-stream parser.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PBEND    = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;

    typedef enum logic [1:0] {
        StNoStatus,
        StWaitD1,
        StWaitD2,
        StSysex
    } parse_state_e;

    typedef enum logic [2:0] {
        KindSilent,
        KindNoteOff,
        KindNoteOn,
        KindPolyAt,
        KindChAt
    } msg_kind_e;

endpackage

// File: rtl/midi_status_decode.sv
// Maps a channel-status nibble to the emitted event kind and its data length.
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [3:0] status,
    output logic [2:0] kind,
    output logic       two_bytes
);

    always_comb begin
        kind      = KindSilent;
        two_bytes = 1'b1;
        case (status)
            NOTE_OFF: kind = KindNoteOff;
            NOTE_ON:  kind = KindNoteOn;
            POLY_AT:  kind = KindPolyAt;
            CH_AT: begin
                kind      = KindChAt;
                two_bytes = 1'b0;
            end
            PROG:     two_bytes = 1'b0;
            default:  ;
        endcase
    end

endmodule

// File: rtl/midi_event_decoder.sv
// Parses the UART MIDI byte stream into one-cycle note-event strobes with
// running status, real-time passthrough, SysEx/system-common discard and channel filtering.
module midi_event_decoder
    import midi_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter bit          VEL0_IS_OFF  = 1'b1
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic       note_channelpress,
    output logic [6:0] note_interface,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic       msg_error,
    output logic [7:0] err_count
);

    parse_state_e state_q, state_d;
    logic [3:0]   status_q, status_d;
    logic [3:0]   chan_q, chan_d;
    logic [6:0]   d1_q, d1_d;

    logic [2:0] kind;
    logic       two_bytes;
    logic       is_data, is_chan, is_syscom;
    logic       complete, data_err;
    logic [6:0] msg_d1, msg_d2;

    logic       pressed_d, released_d, keypress_d, chpress_d, err_d;
    logic [6:0] note_d, vel_d;
    logic [3:0] ch_d;
    logic [7:0] cnt_d;

    midi_status_decode u_status_decode (
        .status    (status_q),
        .kind      (kind),
        .two_bytes (two_bytes)
    );

    // Real-time bytes (F8-FF) fall into none of these classes and are ignored.
    assign is_data   = rx_valid & ~rx_data[7];
    assign is_chan   = rx_valid & rx_data[7] & (rx_data[7:4] != 4'hF);
    assign is_syscom = rx_valid & (rx_data[7:3] == 5'b11110);

    assign msg_d1 = (state_q == StWaitD2) ? d1_q : rx_data[6:0];
    assign msg_d2 = rx_data[6:0];

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            state_q  <= StNoStatus;
            status_q <= 4'h0;
            chan_q   <= 4'h0;
            d1_q     <= 7'h00;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            chan_q   <= chan_d;
            d1_q     <= d1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        chan_d   = chan_q;
        d1_d     = d1_q;
        complete = 1'b0;
        data_err = 1'b0;
        if (is_chan) begin
            state_d  = StWaitD1;
            status_d = rx_data[7:4];
            chan_d   = rx_data[3:0];
        end else if (is_syscom) begin
            status_d = 4'h0;
            chan_d   = 4'h0;
            state_d  = (state_q == StSysex && rx_data == SYSEX_END) ? StNoStatus : StSysex;
        end else if (is_data) begin
            case (state_q)
                StNoStatus: data_err = 1'b1;
                StWaitD1: begin
                    if (two_bytes) begin
                        d1_d    = rx_data[6:0];
                        state_d = StWaitD2;
                    end else begin
                        complete = 1'b1;
                    end
                end
                StWaitD2: begin
                    complete = 1'b1;
                    state_d  = StWaitD1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pressed_d  = 1'b0;
        released_d = 1'b0;
        keypress_d = 1'b0;
        chpress_d  = 1'b0;
        note_d     = note_interface;
        vel_d      = velocity;
        ch_d       = channel;
        err_d      = data_err;
        cnt_d      = (data_err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        if (complete && CHANNEL_MASK[chan_q] && kind != KindSilent) begin
            note_d = msg_d1;
            vel_d  = msg_d2;
            ch_d   = chan_q;
            case (kind)
                KindNoteOn: begin
                    if (msg_d2 == 7'h00 && VEL0_IS_OFF) released_d = 1'b1;
                    else                                pressed_d  = 1'b1;
                end
                KindNoteOff: released_d = 1'b1;
                KindPolyAt:  keypress_d = 1'b1;
                KindChAt: begin
                    chpress_d = 1'b1;
                    note_d    = 7'h00;
                    vel_d     = msg_d1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            note_pressed      <= 1'b0;
            note_released     <= 1'b0;
            note_keypress     <= 1'b0;
            note_channelpress <= 1'b0;
            note_interface    <= 7'h00;
            velocity          <= 7'h00;
            channel           <= 4'h0;
            msg_error         <= 1'b0;
            err_count         <= 8'h00;
        end else begin
            note_pressed      <= pressed_d;
            note_released     <= released_d;
            note_keypress     <= keypress_d;
            note_channelpress <= chpress_d;
            note_interface    <= note_d;
            velocity          <= vel_d;
            channel           <= ch_d;
            msg_error         <= err_d;
            err_count         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_midi_event_decoder.sv
// Directed bench: default-mask instance plus a channel-0-only instance on the same stream.
module tb_midi_event_decoder;

    logic       clk32 = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic       a_pr, a_rl, a_kp, a_cp, a_er;
    logic [6:0] a_note, a_vel;
    logic [3:0] a_ch;
    logic [7:0] a_cnt;

    logic       m_pr, m_rl, m_kp, m_cp, m_er;
    logic [6:0] m_note, m_vel;
    logic [3:0] m_ch;
    logic [7:0] m_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #15 clk32 = ~clk32;

    midi_event_decoder dut_a (
        .clk32             (clk32),
        .rst               (rst),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .note_pressed      (a_pr),
        .note_released     (a_rl),
        .note_keypress     (a_kp),
        .note_channelpress (a_cp),
        .note_interface    (a_note),
        .velocity          (a_vel),
        .channel           (a_ch),
        .msg_error         (a_er),
        .err_count         (a_cnt)
    );

    midi_event_decoder #(.CHANNEL_MASK(16'h0001)) dut_m (
        .clk32             (clk32),
        .rst               (rst),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .note_pressed      (m_pr),
        .note_released     (m_rl),
        .note_keypress     (m_kp),
        .note_channelpress (m_cp),
        .note_interface    (m_note),
        .velocity          (m_vel),
        .channel           (m_ch),
        .msg_error         (m_er),
        .err_count         (m_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe vector order: pressed, released, keypress, channelpress, msg_error.
    task automatic chk_a(input string tag, input logic [4:0] stb, input logic [6:0] note,
                         input logic [6:0] vel, input logic [3:0] ch);
        chk({tag, ".a_stb"}, {27'd0, a_pr, a_rl, a_kp, a_cp, a_er}, {27'd0, stb});
        chk({tag, ".a_data"}, {14'd0, a_note, a_vel, a_ch}, {14'd0, note, vel, ch});
    endtask

    task automatic chk_m(input string tag, input logic [4:0] stb, input logic [6:0] note,
                         input logic [6:0] vel, input logic [3:0] ch);
        chk({tag, ".m_stb"}, {27'd0, m_pr, m_rl, m_kp, m_cp, m_er}, {27'd0, stb});
        chk({tag, ".m_data"}, {14'd0, m_note, m_vel, m_ch}, {14'd0, note, vel, ch});
    endtask

    // Called at a negedge; returns at the next negedge with the result registered.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk32);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk32);
        @(negedge clk32);
        chk_a("reset", 5'b00000, 7'h00, 7'h00, 4'h0);
        chk("reset.cnt", {24'd0, a_cnt}, 32'd0);
        rst = 1'b0;

        // Data with no running status
        send(8'h3C);
        chk_a("orphan1", 5'b00001, 7'h00, 7'h00, 4'h0);
        chk("orphan1.cnt", {24'd0, a_cnt}, 32'd1);
        send(8'h64);
        chk_a("orphan2", 5'b00001, 7'h00, 7'h00, 4'h0);
        chk("orphan2.cnt", {24'd0, a_cnt}, 32'd2);

        // SysEx payload is discarded silently
        send(8'hF0);
        send(8'h01);
        chk_a("sysex.d1", 5'b00000, 7'h00, 7'h00, 4'h0);
        send(8'h02);
        send(8'hF7);
        chk_a("sysex.end", 5'b00000, 7'h00, 7'h00, 4'h0);
        chk("sysex.cnt", {24'd0, a_cnt}, 32'd2);

        // Basic Note-On
        send(8'h90);
        send(8'h3C);
        chk_a("on.partial", 5'b00000, 7'h00, 7'h00, 4'h0);
        send(8'h64);
        chk_a("on.ch0", 5'b10000, 7'h3C, 7'h64, 4'h0);
        chk_m("on.ch0", 5'b10000, 7'h3C, 7'h64, 4'h0);
        @(negedge clk32);
        chk_a("on.idle", 5'b00000, 7'h3C, 7'h64, 4'h0);

        // Running status, back-to-back bytes, vel 0 => release
        send(8'h91);
        send(8'h40);
        send(8'h50);
        chk_a("rs.on", 5'b10000, 7'h40, 7'h50, 4'h1);
        chk_m("rs.masked", 5'b00000, 7'h3C, 7'h64, 4'h0);
        send(8'h40);
        chk_a("rs.d1", 5'b00000, 7'h40, 7'h50, 4'h1);
        send(8'h00);
        chk_a("rs.vel0", 5'b01000, 7'h40, 7'h00, 4'h1);

        // Real-time byte inside a message
        send(8'h92);
        send(8'h3C);
        send(8'hF8);
        chk_a("rt.mid", 5'b00000, 7'h40, 7'h00, 4'h1);
        send(8'h64);
        chk_a("rt.on", 5'b10000, 7'h3C, 7'h64, 4'h2);

        // Channel filtering
        send(8'h95);
        send(8'h3C);
        send(8'h64);
        chk_m("mask.ch5", 5'b00000, 7'h3C, 7'h64, 4'h0);
        chk_a("nomask.ch5", 5'b10000, 7'h3C, 7'h64, 4'h5);
        send(8'h80);
        send(8'h3C);
        send(8'h20);
        chk_m("mask.off", 5'b01000, 7'h3C, 7'h20, 4'h0);

        // Pressure messages
        send(8'hA5);
        send(8'h3C);
        send(8'h30);
        chk_a("polyat", 5'b00100, 7'h3C, 7'h30, 4'h5);
        send(8'hD5);
        send(8'h7F);
        chk_a("chat", 5'b00010, 7'h00, 7'h7F, 4'h5);
        send(8'h11);
        chk_a("chat.rs", 5'b00010, 7'h00, 7'h11, 4'h5);

        // Silent messages leave outputs alone
        send(8'hB0);
        send(8'h07);
        send(8'h64);
        chk_a("cc", 5'b00000, 7'h00, 7'h11, 4'h5);
        send(8'hC3);
        send(8'h05);
        chk_a("prog", 5'b00000, 7'h00, 7'h11, 4'h5);

        // System common outside SysEx: trailing data is not an error
        send(8'hF3);
        send(8'h01);
        chk_a("songsel", 5'b00000, 7'h00, 7'h11, 4'h5);
        chk("songsel.cnt", {24'd0, a_cnt}, 32'd2);

        // Reset mid-message
        send(8'h90);
        send(8'h3C);
        rst = 1'b1;
        #1;
        chk_a("midrst", 5'b00000, 7'h00, 7'h00, 4'h0);
        chk("midrst.cnt", {24'd0, a_cnt}, 32'd0);
        @(negedge clk32);
        rst = 1'b0;
        send(8'h64);
        chk_a("postrst", 5'b00001, 7'h00, 7'h00, 4'h0);
        chk("postrst.cnt", {24'd0, a_cnt}, 32'd1);

        // err_count saturation
        for (int i = 0; i < 256; i++) send(8'h01);
        chk("sat.cnt", {24'd0, a_cnt}, 32'hFF);
        chk("sat.err", {31'd0, a_er}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
